neuron_scan_ctrl: RTL and testbench
===================================

Name: neuron_scan_ctrl

Overview:
Time-step sequencer that sits upstream and downstream of the combinational neuron update block. On each tick it scans every neuron in turn. For each neuron it:
- drives the address to the neuron parameter/potential memories;
- captures the update block's new potential and spike result one cycle later;
- writes the potential back;
- pushes the index of each firing neuron into an internal spike FIFO, which feeds the core's spike output/router stage.

Parameters:
NUM_NEURONS, 256, neurons scanned per time step (>=2).
NEURON_ADDR_WIDTH, 8, width of neuron index, equal to $clog2(NUM_NEURONS).
POTENTIAL_WIDTH, 9, signed membrane potential width.
SPIKE_FIFO_DEPTH, 16, spike FIFO entries; power of two, >=2.

Ports:
clk_i  input  1  clock, all state on rising edge.
rst_i  input  1  asynchronous active-high reset.
tick_i  input  1  start one time step; sampled only in IDLE.
busy_o  output  1  high while a scan is in progress (READ/EVAL/DONE).
done_o  output  1  one-cycle pulse: last neuron written back.
tick_overrun_o  output  1  sticky: tick_i seen while not IDLE.
neuron_addr_o  output  NEURON_ADDR_WIDTH  current neuron index to memories.
mem_rd_en_o  output  1  read strobe; memories return data next cycle.
nb_write_potential_i  input  POTENTIAL_WIDTH  signed new potential from update block.
nb_spike_i  input  1  spike result from update block.
pot_we_o  output  1  potential write enable.
pot_waddr_o  output  NEURON_ADDR_WIDTH  write address.
pot_wdata_o  output  POTENTIAL_WIDTH  write data.
spike_valid_o  output  1  FIFO non-empty.
spike_id_o  output  NEURON_ADDR_WIDTH  FIFO head neuron index.
spike_ready_i  input  1  consumer accepts head when valid.

Behaviour:
Reset values:
- all outputs 0; state IDLE; neuron counter 0; FIFO empty; tick_overrun_o cleared.
- Reset mid-scan aborts immediately. No write-back and no done_o are produced.

State machine IDLE -> READ -> EVAL -> (READ | DONE) -> IDLE:
- IDLE: on tick_i=1, clear counter and go to READ.
- READ: mem_rd_en_o=1, neuron_addr_o=counter; always go to EVAL next cycle.
- EVAL: memory data are valid and update-block outputs are combinationally valid.
  - Commit condition: !(nb_spike_i && fifo_full).
  - On commit: pot_we_o=1, pot_waddr_o=counter, pot_wdata_o=nb_write_potential_i. If nb_spike_i, push counter into the FIFO.
  - After commit: if counter==NUM_NEURONS-1 go to DONE, else increment counter and go to READ.
  - No commit (stall): hold EVAL with pot_we_o=0. neuron_addr_o stays stable so the update-block inputs stay stable.
- DONE: done_o=1 for this single cycle, then IDLE.

Timing and throughput:
- 2 cycles per neuron without stalls. A full step is 2*NUM_NEURONS+1 cycles after tick acceptance.
- busy_o=1 in READ, EVAL and DONE.

Write-back and push are atomic. A neuron's potential is never written unless its spike, if any, is enqueued in the same cycle.

FIFO:
- First-word-fall-through: spike_valid_o = count!=0, spike_id_o = head.
- Pop occurs when spike_valid_o && spike_ready_i.
- Full means count==SPIKE_FIFO_DEPTH. When full, a push stalls even if a pop happens in the same cycle. The stall releases on the following cycle.
- Push and pop in the same cycle while not full: count is unchanged.
- Read and write pointers wrap modulo SPIKE_FIFO_DEPTH.
- FIFO contents persist across time steps; it drains independently of scanning.

Overrun:
- tick_i=1 in any state other than IDLE is ignored and sets tick_overrun_o.
- tick_overrun_o clears only on reset.

Potential arithmetic and saturation belong to the update block. This block passes data through with no width change.

Optional Feature:
SPIKE_COUNT_EN:
- When defined: adds output spike_count_o of width NEURON_ADDR_WIDTH+1. It holds the number of spikes pushed in the most recently completed step and updates in the DONE cycle. An internal counter clears at tick acceptance and increments on each committed push. Reset value is 0.
- When undefined: no port and no counter logic.

Test Plan:
- NUM_NEURONS=4, DEPTH=4, nb_spike_i=0, tick pulse -> mem_rd_en_o on addresses 0,1,2,3. pot_we_o pulses at addresses 0..3 carrying the nb_write_potential_i values (e.g. -5,0,7,255 sign-masked). done_o pulses 9 cycles after tick acceptance. FIFO stays empty.
- Neurons 1 and 3 spike, spike_ready_i=1 -> spike_id_o outputs 1 then 3, each valid the cycle after its EVAL commit. With SPIKE_COUNT_EN, spike_count_o=2 at done.
- DEPTH=2, all 4 neurons spike, spike_ready_i=0 -> neuron 2 stalls in EVAL with pot_we_o=0 and neuron_addr_o=2 held. Raising spike_ready_i for 1 cycle pops id 0. The next cycle commits neuron 2. All four writes eventually happen exactly once.
- tick_i asserted mid-scan -> scan unaffected, tick_overrun_o=1 and stays set after done_o.
- rst_i asserted during EVAL of neuron 2 -> all outputs 0 asynchronously, FIFO empty, no done_o. A following tick restarts from address 0.
- FIFO full with simultaneous pop and spiking EVAL -> no push that cycle. Push commits the next cycle; count is never greater than DEPTH.

Source files
------------

// File: rtl/neuron_scan_ctrl.sv
// neuron_scan_ctrl: per-time-step scan sequencer around the combinational
// neuron update block. It walks every neuron (READ then EVAL), writes each new
// potential back, and queues the index of each firing neuron in a
// first-word-fall-through spike FIFO.
// Optional build macro SPIKE_COUNT_EN adds spike_count_o, the number of spikes
// pushed during the most recently completed time step.
module neuron_scan_ctrl #(
  parameter int NUM_NEURONS       = 256,
  parameter int NEURON_ADDR_WIDTH = 8,
  parameter int POTENTIAL_WIDTH   = 9,
  parameter int SPIKE_FIFO_DEPTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         tick_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         tick_overrun_o,
  output logic [NEURON_ADDR_WIDTH-1:0] neuron_addr_o,
  output logic                         mem_rd_en_o,
  input  logic [POTENTIAL_WIDTH-1:0]   nb_write_potential_i,
  input  logic                         nb_spike_i,
  output logic                         pot_we_o,
  output logic [NEURON_ADDR_WIDTH-1:0] pot_waddr_o,
  output logic [POTENTIAL_WIDTH-1:0]   pot_wdata_o,
  output logic                         spike_valid_o,
  output logic [NEURON_ADDR_WIDTH-1:0] spike_id_o,
  input  logic                         spike_ready_i
`ifdef SPIKE_COUNT_EN
  ,
  output logic [NEURON_ADDR_WIDTH:0]   spike_count_o
`endif
);

  localparam int PTR_W = $clog2(SPIKE_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, READ, EVAL, DONE} state_t;

  state_t                       state;
  state_t                       next_state;
  logic [NEURON_ADDR_WIDTH-1:0] counter;
  logic                         last_neuron;
  logic                         fifo_full;
  logic                         fifo_nonempty;
  logic                         commit;
  logic                         push;
  logic                         pop;
  logic [NEURON_ADDR_WIDTH-1:0] fifo_mem [SPIKE_FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [CNT_W-1:0]             fifo_count;

  // A spiking neuron may only commit when its index can be enqueued, so the
  // write-back and the push always happen together.
  assign last_neuron   = (counter == NEURON_ADDR_WIDTH'(NUM_NEURONS - 1));
  assign fifo_full     = (fifo_count == CNT_W'(SPIKE_FIFO_DEPTH));
  assign fifo_nonempty = (fifo_count != '0);
  assign commit        = (state == EVAL) && !(nb_spike_i && fifo_full);
  assign push          = commit && nb_spike_i;
  assign pop           = fifo_nonempty && spike_ready_i;

  // State register; reset aborts any scan in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: EVAL holds while the FIFO blocks a spiking neuron.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (tick_i) next_state = READ;
      READ: next_state = EVAL;
      EVAL: if (commit) next_state = last_neuron ? DONE : READ;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode; address and write-back fields are zero outside their phases.
  always_comb begin
    busy_o        = (state != IDLE);
    done_o        = (state == DONE);
    mem_rd_en_o   = (state == READ);
    neuron_addr_o = '0;
    pot_we_o      = 1'b0;
    pot_waddr_o   = '0;
    pot_wdata_o   = '0;
    spike_valid_o = fifo_nonempty;
    spike_id_o    = fifo_nonempty ? fifo_mem[rd_ptr] : '0;
    if (state == READ || state == EVAL) neuron_addr_o = counter;
    if (commit) begin
      pot_we_o    = 1'b1;
      pot_waddr_o = counter;
      pot_wdata_o = nb_write_potential_i;
    end
  end

  // Neuron index: cleared on tick acceptance, advanced after each commit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      counter <= '0;
    end else if (state == IDLE && tick_i) begin
      counter <= '0;
    end else if (commit && !last_neuron) begin
      counter <= counter + NEURON_ADDR_WIDTH'(1);
    end
  end

  // Sticky flag for ticks that arrive while a step is still running.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                         tick_overrun_o <= 1'b0;
    else if (tick_i && state != IDLE)  tick_overrun_o <= 1'b1;
  end

  // FIFO storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= counter;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the depth.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

`ifdef SPIKE_COUNT_EN
  logic [NEURON_ADDR_WIDTH:0] step_count;

  // Per-step spike tally, published to spike_count_o in the DONE cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      step_count    <= '0;
      spike_count_o <= '0;
    end else begin
      if (state == IDLE && tick_i) step_count <= '0;
      else if (push)               step_count <= step_count + (NEURON_ADDR_WIDTH+1)'(1);
      if (state == DONE)           spike_count_o <= step_count;
    end
  end
`endif

endmodule

// File: tb/tb_neuron_scan_ctrl.sv
// tb_neuron_scan_ctrl: directed bench for neuron_scan_ctrl with 4 neurons and a
// 2-entry spike FIFO. Build with SPIKE_COUNT_EN defined to also check the
// per-step spike count.
module tb_neuron_scan_ctrl;

  localparam int N     = 4;
  localparam int AW    = 2;
  localparam int PW    = 9;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          busy, done, overrun, rd_en, pot_we, spike_valid;
  logic [AW-1:0] addr, waddr, spike_id;
  logic [PW-1:0] pot_wdata;
  logic [PW-1:0] nb_pot = '0;
  logic          nb_spike = 1'b0;
  logic          ready = 1'b0;
`ifdef SPIKE_COUNT_EN
  logic [AW:0]   spike_count;
`endif

  int checks = 0;
  int errors = 0;

  neuron_scan_ctrl #(
    .NUM_NEURONS(N), .NEURON_ADDR_WIDTH(AW),
    .POTENTIAL_WIDTH(PW), .SPIKE_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick),
    .busy_o(busy), .done_o(done), .tick_overrun_o(overrun),
    .neuron_addr_o(addr), .mem_rd_en_o(rd_en),
    .nb_write_potential_i(nb_pot), .nb_spike_i(nb_spike),
    .pot_we_o(pot_we), .pot_waddr_o(waddr), .pot_wdata_o(pot_wdata),
    .spike_valid_o(spike_valid), .spike_id_o(spike_id),
    .spike_ready_i(ready)
`ifdef SPIKE_COUNT_EN
    , .spike_count_o(spike_count)
`endif
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic expect_read(input int a);
    check_output("read_rd_en", rd_en, 1);
    check_output("read_addr", addr, a);
    check_output("read_busy", busy, 1);
    check_output("read_we", pot_we, 0);
    step();
  endtask

  task automatic expect_eval(input int a, input logic [PW-1:0] pot, input logic spk, input logic exp_we);
    nb_pot   = pot;
    nb_spike = spk;
    #1;
    check_output("eval_we", pot_we, exp_we);
    check_output("eval_addr", addr, a);
    check_output("eval_rd_en", rd_en, 0);
    if (exp_we) begin
      check_output("eval_waddr", waddr, a);
      check_output("eval_wdata", pot_wdata, pot);
    end
    step();
    nb_spike = 1'b0;
    nb_pot   = '0;
  endtask

  task automatic expect_done();
    check_output("done_pulse", done, 1);
    check_output("done_busy", busy, 1);
    step();
    check_output("done_cleared", done, 0);
    check_output("idle_busy", busy, 0);
  endtask

  task automatic check_fifo(input logic v, input int id);
    check_output("fifo_valid", spike_valid, v);
    if (v) check_output("fifo_id", spike_id, id);
  endtask

  task automatic check_reset_outputs();
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_overrun", overrun, 0);
    check_output("rst_rd_en", rd_en, 0);
    check_output("rst_addr", addr, 0);
    check_output("rst_we", pot_we, 0);
    check_output("rst_waddr", waddr, 0);
    check_output("rst_wdata", pot_wdata, 0);
    check_output("rst_valid", spike_valid, 0);
    check_output("rst_id", spike_id, 0);
`ifdef SPIKE_COUNT_EN
    check_output("rst_spike_count", spike_count, 0);
`endif
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    step();

    // Plain scan, no spikes: four write-backs then done after 9 cycles
    ready = 1'b1;
    do_tick();
    expect_read(0); expect_eval(0, 9'h1FB, 1'b0, 1'b1);
    expect_read(1); expect_eval(1, 9'h000, 1'b0, 1'b1);
    expect_read(2); expect_eval(2, 9'h007, 1'b0, 1'b1);
    expect_read(3); expect_eval(3, 9'h0FF, 1'b0, 1'b1);
    expect_done();
    check_fifo(1'b0, 0);
    check_output("overrun_clear", overrun, 0);

    // Neurons 1 and 3 spike with the consumer always ready
    do_tick();
    expect_read(0); expect_eval(0, 9'h003, 1'b0, 1'b1);
    expect_read(1); expect_eval(1, 9'h040, 1'b1, 1'b1);
    check_fifo(1'b1, 1);
    expect_read(2);
    check_fifo(1'b0, 0);
    expect_eval(2, 9'h1F0, 1'b0, 1'b1);
    expect_read(3); expect_eval(3, 9'h080, 1'b1, 1'b1);
    check_fifo(1'b1, 3);
    expect_done();
    check_fifo(1'b0, 0);
`ifdef SPIKE_COUNT_EN
    check_output("spike_count_two", spike_count, 2);
`endif

    // All neurons spike into a 2-deep FIFO with the consumer stalled
    ready = 1'b0;
    do_tick();
    expect_read(0); expect_eval(0, 9'h011, 1'b1, 1'b1);
    check_fifo(1'b1, 0);
    expect_read(1); expect_eval(1, 9'h012, 1'b1, 1'b1);
    check_fifo(1'b1, 0);
    expect_read(2);
    expect_eval(2, 9'h013, 1'b1, 1'b0);
    expect_eval(2, 9'h013, 1'b1, 1'b0);
    ready = 1'b1;
    check_fifo(1'b1, 0);
    expect_eval(2, 9'h013, 1'b1, 1'b0);
    ready = 1'b0;
    check_fifo(1'b1, 1);
    expect_eval(2, 9'h013, 1'b1, 1'b1);
    check_fifo(1'b1, 1);
    expect_read(3);
    expect_eval(3, 9'h014, 1'b1, 1'b0);
    ready = 1'b1;
    expect_eval(3, 9'h014, 1'b1, 1'b0);
    ready = 1'b0;
    check_fifo(1'b1, 2);
    expect_eval(3, 9'h014, 1'b1, 1'b1);
    expect_done();
`ifdef SPIKE_COUNT_EN
    check_output("spike_count_four", spike_count, 4);
`endif
    check_fifo(1'b1, 2);
    ready = 1'b1;
    step();
    check_fifo(1'b1, 3);
    step();
    check_fifo(1'b0, 0);

    // Tick during a scan is ignored but latches the overrun flag
    do_tick();
    tick = 1'b1;
    expect_read(0);
    tick = 1'b0;
    check_output("overrun_set", overrun, 1);
    expect_eval(0, 9'h021, 1'b0, 1'b1);
    expect_read(1); expect_eval(1, 9'h022, 1'b0, 1'b1);
    expect_read(2); expect_eval(2, 9'h023, 1'b0, 1'b1);
    expect_read(3); expect_eval(3, 9'h024, 1'b0, 1'b1);
    expect_done();
    check_output("overrun_sticky", overrun, 1);

    // Reset during EVAL of neuron 2 with a spike queued
    ready = 1'b0;
    do_tick();
    expect_read(0); expect_eval(0, 9'h005, 1'b1, 1'b1);
    expect_read(1);
    check_fifo(1'b1, 0);
    expect_eval(1, 9'h006, 1'b0, 1'b1);
    expect_read(2);
    nb_pot = 9'h009;
    #1;
    check_output("pre_reset_we", pot_we, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    nb_pot = '0;
    step();
    check_output("in_reset_done", done, 0);
    rst = 1'b0;
    step();
    check_output("post_reset_done", done, 0);
    check_output("post_reset_busy", busy, 0);
    check_fifo(1'b0, 0);

    // Fresh step after reset restarts from address 0
    ready = 1'b1;
    do_tick();
    expect_read(0); expect_eval(0, 9'h031, 1'b0, 1'b1);
    expect_read(1); expect_eval(1, 9'h032, 1'b0, 1'b1);
    expect_read(2); expect_eval(2, 9'h033, 1'b0, 1'b1);
    expect_read(3); expect_eval(3, 9'h034, 1'b0, 1'b1);
    expect_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
